// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA 640x480@60 timing constants, default window geometry and flag type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int H_TOTAL    = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;   // 800

  // Vertical timing, in lines
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;
  localparam int V_TOTAL    = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;   // 525

  // Sync pulses are active low over [START, END)
  localparam int H_SYNC_START = H_VIS_DEF + H_FP_DEF;                      // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;                 // 752
  localparam int V_SYNC_START = V_VIS_DEF + V_FP_DEF;                      // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;                 // 492

  // Default scaler window placement; size must match the scaler's display size
  localparam int WIN_X0_DEF = 220;
  localparam int WIN_Y0_DEF = 165;
  localparam int WIN_W_DEF  = 200;
  localparam int WIN_H_DEF  = 150;

  // Per-pixel flags carried alongside the scaler latency
  typedef struct packed {
    logic hs;    // horizontal sync, active low
    logic vs;    // vertical sync, active low
    logic vis;   // inside the 640x480 visible area
    logic win;   // inside the scaler window
    logic brd;   // on the 1-pixel ring around the window
  } sync_flags_t;

  // Value held while in reset: syncs deasserted, nothing visible
  localparam sync_flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, win: 1'b0, brd: 1'b0};

  // Half-open interval test [lo, hi)
  function automatic logic in_range(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_flag_delay.sv
// vga_flag_delay: shift register that delays the per-pixel sync/window flags.
// Latency: DEPTH cycles from flags_i to flags_o.
// Backpressure: none; shifts every clock.
module vga_flag_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  sync_flags_t flags_i,
  output sync_flags_t flags_o
);

  sync_flags_t stage_q [DEPTH];

  // Shift flags one stage per pixel; reset parks every stage at the idle value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= FLAGS_IDLE;
      end
    end else begin
      stage_q[0] <= flags_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign flags_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_window_ctrl.sv
// vga_window_ctrl: VGA timing generator that places the scaler's RGB window inside the visible frame.
// Latency: counter to VGA pins 1+PIPE_LAT cycles; READ_Request to VGA_R/G/B exactly PIPE_LAT cycles.
// Backpressure: none; free-running pixel timing, scaler must return RGB in step with READ_Request.
// Build option: define WIN_BORDER_EN to draw a white 1-pixel ring just outside the window.
// RST_N asserts asynchronously; its release is expected to be synchronous to VGA_CLK.
module vga_window_ctrl
  import vga_timing_pkg::*;
#(
  parameter int          H_VIS    = H_VIS_DEF,
  parameter int          H_FP     = H_FP_DEF,
  parameter int          H_SYNC   = H_SYNC_DEF,
  parameter int          H_BP     = H_BP_DEF,
  parameter int          V_VIS    = V_VIS_DEF,
  parameter int          V_FP     = V_FP_DEF,
  parameter int          V_SYNC   = V_SYNC_DEF,
  parameter int          V_BP     = V_BP_DEF,
  parameter int          WIN_X0   = WIN_X0_DEF,
  parameter int          WIN_Y0   = WIN_Y0_DEF,
  parameter int          WIN_W    = WIN_W_DEF,
  parameter int          WIN_H    = WIN_H_DEF,
  parameter int          PIPE_LAT = 2,
  parameter logic [23:0] BG_RGB   = 24'h000000
) (
  input  logic       VGA_CLK,
  input  logic       RST_N,
  input  logic [7:0] iRed,
  input  logic [7:0] iGreen,
  input  logic [7:0] iBlue,
  output logic       READ_Request,
  output logic       oREQ_VS,
  output logic       oREQ_HS,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  // Geometry sanity: the window must fit the visible area and the latency stay in range
  generate
    if (WIN_X0 + WIN_W > H_VIS) begin : g_err_win_x
      $error("vga_window_ctrl: WIN_X0+WIN_W exceeds H_VIS");
    end
    if (WIN_Y0 + WIN_H > V_VIS) begin : g_err_win_y
      $error("vga_window_ctrl: WIN_Y0+WIN_H exceeds V_VIS");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_err_lat
      $error("vga_window_ctrl: PIPE_LAT must be within 1..8");
    end
`ifdef WIN_BORDER_EN
    if (WIN_X0 < 1 || WIN_Y0 < 1) begin : g_err_brd
      $error("vga_window_ctrl: border ring needs WIN_X0 >= 1 and WIN_Y0 >= 1");
    end
`endif
  endgenerate

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  int            x_pos, y_pos;
  sync_flags_t   s0_q, s0_d;
  sync_flags_t   tap;
  logic [23:0]   data_q, data_d;
  logic [23:0]   rgb_out;

  // Raster position: h wraps at the line end and carries into v, v wraps at the frame end
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Raster counters restart from (0,0) on reset
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Decode sync, visibility, window and border membership of the current raster position
  always_comb begin
    x_pos    = int'(h_q);
    y_pos    = int'(v_q);
    s0_d     = FLAGS_IDLE;
    s0_d.hs  = !in_range(x_pos, HS_START, HS_END);
    s0_d.vs  = !in_range(y_pos, VS_START, VS_END);
    s0_d.vis = (x_pos < H_VIS) && (y_pos < V_VIS);
    s0_d.win = in_range(x_pos, WIN_X0, WIN_X0 + WIN_W) &&
               in_range(y_pos, WIN_Y0, WIN_Y0 + WIN_H);
`ifdef WIN_BORDER_EN
    s0_d.brd = (((x_pos == WIN_X0 - 1) || (x_pos == WIN_X0 + WIN_W)) &&
                in_range(y_pos, WIN_Y0 - 1, WIN_Y0 + WIN_H + 1)) ||
               (((y_pos == WIN_Y0 - 1) || (y_pos == WIN_Y0 + WIN_H)) &&
                in_range(x_pos, WIN_X0 - 1, WIN_X0 + WIN_W + 1));
`endif
  end

  // Stage-0 register: these flags drive the scaler directly, undelayed
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      s0_q <= FLAGS_IDLE;
    end else begin
      s0_q <= s0_d;
    end
  end

  assign READ_Request = s0_q.win;
  assign oREQ_HS      = s0_q.hs;
  assign oREQ_VS      = s0_q.vs;

  // Delay the flags by the scaler's RGB latency so the DAC sees them pixel-aligned
  vga_flag_delay #(
    .DEPTH (PIPE_LAT)
  ) u_flag_delay (
    .clk_i   (VGA_CLK),
    .rst_ni  (RST_N),
    .flags_i (s0_q),
    .flags_o (tap)
  );

  assign data_d = {iRed, iGreen, iBlue};

  // Capture scaler RGB on the same edge that loads the flag tap, so both describe one pixel
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Pick the pixel colour: black in blanking, scaler data in the window, ring or background elsewhere
  always_comb begin
    rgb_out = BG_RGB;
    if (!tap.vis) begin
      rgb_out = '0;
    end else if (tap.win) begin
      rgb_out = data_q;
    end else if (tap.brd) begin
      rgb_out = 24'hFFFFFF;
    end
  end

  assign VGA_HS      = tap.hs;
  assign VGA_VS      = tap.vs;
  assign VGA_BLANK_N = tap.vis;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = rgb_out[23:16];
  assign VGA_G       = rgb_out[15:8];
  assign VGA_B       = rgb_out[7:0];

endmodule

// File: tb/tb_vga_window_ctrl.sv
// tb_vga_window_ctrl: directed bench for vga_window_ctrl on a reduced raster geometry.
// A position-based model predicts every output each cycle; literal checks pin periods and pixels.
// Works with or without WIN_BORDER_EN defined.
module tb_vga_window_ctrl;

  // Reduced raster so several frames fit in a short run
  localparam int HV = 64, HF = 4, HSY = 8, HB = 4;   // 80 clocks per line
  localparam int VV = 48, VF = 3, VSY = 2, VB = 4;   // 57 lines per frame
  localparam int HT = 80;
  localparam int VT = 57;
  localparam int FRAME = HT * VT;                    // 4560
  localparam int X0 = 20, Y0 = 15, W = 20, H = 10, PL = 2;
  localparam logic [23:0] BG        = 24'h123456;
  localparam logic [23:0] CONST_RGB = 24'hAA55CC;
`ifdef WIN_BORDER_EN
  localparam bit BRD_EN = 1'b1;
`else
  localparam bit BRD_EN = 1'b0;
`endif
  // {READ_Request, oREQ_HS, oREQ_VS, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, RGB}
  localparam logic [30:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

  logic       VGA_CLK = 1'b0;
  logic       RST_N   = 1'b0;
  logic [7:0] iRed = 8'h00, iGreen = 8'h00, iBlue = 8'h00;
  logic       READ_Request, oREQ_VS, oREQ_HS, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_edge = 0;
  bit          const_mode = 1'b0;
  logic [23:0] drv = 24'h000000;

  vga_window_ctrl #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(W), .WIN_H(H),
    .PIPE_LAT(PL), .BG_RGB(BG)
  ) dut (
    .VGA_CLK(VGA_CLK), .RST_N(RST_N),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .READ_Request(READ_Request), .oREQ_VS(oREQ_VS), .oREQ_HS(oREQ_HS),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // Clock edges seen since reset release
  always @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) n_edge = 0;
    else        n_edge = n_edge + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [30:0] dut_vec();
    return {READ_Request, oREQ_HS, oREQ_VS, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
            VGA_R, VGA_G, VGA_B};
  endfunction

  // Raster position p counts pixels from (0,0) of the first frame after reset
  function automatic bit f_hs(input int p);
    int x = p % HT;
    return !(x >= HV + HF && x < HV + HF + HSY);
  endfunction
  function automatic bit f_vs(input int p);
    int y = (p / HT) % VT;
    return !(y >= VV + VF && y < VV + VF + VSY);
  endfunction
  function automatic bit f_vis(input int p);
    return ((p % HT) < HV) && (((p / HT) % VT) < VV);
  endfunction
  function automatic bit f_win(input int p);
    int x = p % HT;
    int y = (p / HT) % VT;
    return (x >= X0 && x < X0 + W) && (y >= Y0 && y < Y0 + H);
  endfunction
  function automatic bit f_brd(input int p);
    int x = p % HT;
    int y = (p / HT) % VT;
    bit col = (x == X0 - 1 || x == X0 + W) && (y >= Y0 - 1 && y <= Y0 + H);
    bit row = (y == Y0 - 1 || y == Y0 + H) && (x >= X0 - 1 && x <= X0 + W);
    return BRD_EN && (col || row);
  endfunction

  // Outputs after edge n: stage 0 shows pixel n-1, the VGA pins show pixel n-1-PL
  function automatic logic [30:0] model(input int n, input logic rst_n, input logic [23:0] d);
    int p0 = n - 1;
    int p1 = n - 1 - PL;
    logic [23:0] rgb = 24'h000000;
    if (!rst_n) return RST_VEC;
    if (p1 >= 0 && f_vis(p1)) begin
      if (f_win(p1))      rgb = d;
      else if (f_brd(p1)) rgb = 24'hFFFFFF;
      else                rgb = BG;
    end
    return {(p0 >= 0) && f_win(p0), (p0 < 0) || f_hs(p0), (p0 < 0) || f_vs(p0),
            (p1 < 0) || f_hs(p1), (p1 < 0) || f_vs(p1), (p1 >= 0) && f_vis(p1), 1'b0, rgb};
  endfunction

  // Every-cycle model comparison, then present the next scaler pixel
  always @(negedge VGA_CLK) begin
    check("cycle_model", {1'b0, dut_vec()}, {1'b0, model(n_edge, RST_N, drv)});
    if (const_mode) drv = CONST_RGB;
    else            drv = 24'($urandom);
    {iRed, iGreen, iBlue} = drv;
  end

  function automatic logic sig(input int sel);
    return (sel == 0) ? VGA_HS : VGA_VS;
  endfunction

  // Low time and fall-to-fall period of VGA_HS (sel 0) or VGA_VS (sel 1); -1 on timeout
  task automatic measure(input int sel, input int bound, output int low, output int period);
    logic s, prev;
    int   c = 0;
    bit   found = 1'b0, in_low = 1'b1;
    low = -1; period = -1;
    prev = sig(sel);
    while (!found && c < bound) begin
      @(negedge VGA_CLK); c++;
      s = sig(sel);
      if (prev && !s) found = 1'b1;
      prev = s;
    end
    if (!found) return;
    low = 1; period = 1; found = 1'b0; c = 0;
    while (!found && c < bound) begin
      @(negedge VGA_CLK); c++;
      s = sig(sel);
      if (s) begin
        in_low = 1'b0; period++;
      end else if (!in_low) begin
        found = 1'b1;
      end else begin
        low++; period++;
      end
    end
    if (!found) period = -1;
  endtask

  // Advance to the negedge where the VGA pins show pixel (x,y)
  task automatic wait_pos(input int x, input int y, output bit ok);
    int tgt = y * HT + x;
    int c = 0;
    int p;
    ok = 1'b0;
    while (!ok && c < FRAME + 16) begin
      @(negedge VGA_CLK); c++;
      p = n_edge - 1 - PL;
      if (p >= 0 && (p % FRAME) == tgt) ok = 1'b1;
    end
  endtask

  task automatic check_pix(input string name, input int x, input int y, input logic [24:0] exp);
    bit ok;
    wait_pos(x, y, ok);
    check({name, "_reached"}, 32'(ok), 32'd1);
    check(name, {7'd0, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, {7'd0, exp});
  endtask

  initial begin
    int lo, per, c, hi, rises, bad_run, aa_cnt, aa_rises, bad_lag, run, rr_rise;
    int first_ovs, first_vs;
    logic rr, rr_prev, aa, aa_prev;
    bit ok;

    // Reset state
    repeat (3) @(negedge VGA_CLK);
    check("reset_state", {1'b0, dut_vec()}, {1'b0, RST_VEC});
    #2 RST_N = 1'b1;

    // Line and frame timing on the DAC syncs
    measure(0, 3 * HT, lo, per);
    check("hs_low", lo, HSY);                 // 8
    check("hs_period", per, HT);              // 80
    measure(1, 2 * FRAME + HT, lo, per);
    check("vs_low", lo, VSY * HT);            // 160
    check("vs_period", per, FRAME);           // 4560

    // One frame of READ_Request and window data with constant scaler colour
    const_mode = 1'b1;
    hi = 0; rises = 0; bad_run = 0; aa_cnt = 0; aa_rises = 0; bad_lag = 0;
    run = 0; rr_rise = -100; rr_prev = READ_Request; aa_prev = 1'b0;
    for (int cyc = 0; cyc < FRAME; cyc++) begin
      @(negedge VGA_CLK);
      rr = READ_Request;
      aa = (VGA_R == 8'hAA);
      if (rr && !rr_prev) begin rises++; rr_rise = cyc; run = 0; end
      if (rr) begin hi++; run++; end
      if (!rr && rr_prev && run != W) bad_run++;
      if (aa) aa_cnt++;
      if (aa && !aa_prev) begin aa_rises++; if (cyc - rr_rise != PL) bad_lag++; end
      rr_prev = rr;
      aa_prev = aa;
    end
    check("rr_high_cycles", hi, W * H);       // 200
    check("rr_rises", rises, H);              // 10
    check("rr_bad_runs", bad_run, 0);
    check("aa_cycles", aa_cnt, W * H);        // 200
    check("aa_runs", aa_rises, H);            // 10
    check("aa_lag_errors", bad_lag, 0);

    // Hand-picked pixels, in raster order within one frame
    check_pix("pix_0_0", 0, 0, {1'b1, BG});
    check_pix("pix_64_0", 64, 0, {1'b0, 24'h000000});
    check_pix("pix_19_17", 19, 17, {1'b1, BRD_EN ? 24'hFFFFFF : BG});
    check_pix("pix_20_17", 20, 17, {1'b1, CONST_RGB});
    check_pix("pix_40_20", 40, 20, {1'b1, BRD_EN ? 24'hFFFFFF : BG});
    check_pix("pix_63_47", 63, 47, {1'b1, BG});

    // Reset mid-frame, then timing restarts from (0,0)
    const_mode = 1'b0;
    wait_pos(10, 30, ok);
    check("reach_v30", 32'(ok), 32'd1);
    #2 RST_N = 1'b0;
    #1 check("async_reset", {1'b0, dut_vec()}, {1'b0, RST_VEC});
    repeat (3) @(negedge VGA_CLK);
    #2 RST_N = 1'b1;
    c = 0; first_ovs = -1; first_vs = -1;
    while (first_vs < 0 && c < 2 * FRAME) begin
      @(negedge VGA_CLK); c++;
      if (first_ovs < 0 && !oREQ_VS) first_ovs = c;
      if (!VGA_VS) first_vs = c;
    end
    check("first_oreq_vs", first_ovs, 51 * HT + 1);        // 4081
    check("first_vga_vs", first_vs, 51 * HT + 1 + PL);     // 4083

    repeat (2) @(negedge VGA_CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
